// File: rtl/ifetch_queue_if.sv
// Fetch-side bus of the instruction prefetch queue.
// The slave modport is the queue itself. The master modport is whatever drives it:
// the PMEM data return, the EX redirect and the fetch-stage ready.
interface ifetch_queue_if #(
  parameter int unsigned PC_WIDTH        = 12,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2      = 2
);
  logic                       in_set_pc;
  logic [PC_WIDTH-1:0]        in_branch_pc;
  logic [PMEM_WORD_WIDTH-1:0] in_pmem_word;
  logic [PC_WIDTH-1:0]        out_pmem_addr;
  logic                       in_ready;
  logic                       out_valid;
  logic [PMEM_WORD_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]        out_pc;
  logic [DEPTH_LOG2:0]        out_level;

  modport master (
    output in_set_pc, in_branch_pc, in_pmem_word, in_ready,
    input  out_pmem_addr, out_valid, out_instr, out_pc, out_level
  );

  modport slave (
    input  in_set_pc, in_branch_pc, in_pmem_word, in_ready,
    output out_pmem_addr, out_valid, out_instr, out_pc, out_level
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between program memory and the fetch stage.
// It drives the PMEM read address. It captures each registered read word with its PC in a
// small FIFO and presents the head entry to fetch through a valid/ready handshake.
// An EX redirect (in_set_pc) flushes the queue and restarts fetching at in_branch_pc.
// Optional macro IFQ_BYPASS_EN: when the FIFO is empty, the word returning from PMEM is
// presented directly to fetch. This saves one cycle of latency.
module ifetch_queue #(
  parameter int unsigned PC_WIDTH        = 12,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned PC_INCREMENT    = 2,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DEPTH_LOG2      = 2,
  parameter int unsigned RESET_PC        = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  ifetch_queue_if.slave        ifq_io
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;

  logic [PC_WIDTH-1:0]        fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]        req_pc_q, req_pc_d;
  logic                       req_inflight_q, req_inflight_d;
  logic [DEPTH_LOG2-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [PMEM_WORD_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [PC_WIDTH-1:0]        pc_mem_q [DEPTH];

  logic            set_pc;
  logic [CntW:0]   occupancy;
  logic            issue;
  logic            head_valid;
  logic            bypass;
  logic            push;
  logic            pop;

  assign set_pc     = ifq_io.in_set_pc;
  // The in-flight read is counted as occupied, so the FIFO can never overflow.
  assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, req_inflight_q};
  assign issue      = !set_pc && (occupancy < (CntW + 1)'(DEPTH));
  assign head_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = (count_q == '0) && req_inflight_q && !set_pc;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that fetch accepts right away is never written to storage.
  assign push = req_inflight_q && !set_pc && !(bypass && ifq_io.in_ready);
  assign pop  = head_valid && ifq_io.in_ready && !set_pc;

  assign ifq_io.out_pmem_addr = fetch_pc_q;
  assign ifq_io.out_level     = count_q;

  // Head presentation: stored entry first, then the bypassed PMEM word, otherwise zeros.
  always_comb begin
    ifq_io.out_valid = 1'b0;
    ifq_io.out_instr = '0;
    ifq_io.out_pc    = '0;
    if (head_valid) begin
      ifq_io.out_valid = 1'b1;
      ifq_io.out_instr = instr_mem_q[rd_ptr_q];
      ifq_io.out_pc    = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      ifq_io.out_valid = 1'b1;
      ifq_io.out_instr = ifq_io.in_pmem_word;
      ifq_io.out_pc    = req_pc_q;
    end
  end

  // Next-state logic: a redirect overrides issue, push and pop.
  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    req_inflight_d = req_inflight_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    if (set_pc) begin
      fetch_pc_d     = ifq_io.in_branch_pc;
      req_inflight_d = 1'b0;
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      count_d        = '0;
    end else begin
      if (issue) begin
        req_inflight_d = 1'b1;
        req_pc_d       = fetch_pc_q;
        fetch_pc_d     = fetch_pc_q + PC_WIDTH'(PC_INCREMENT);
      end else begin
        req_inflight_d = 1'b0;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q     <= PC_WIDTH'(RESET_PC);
      req_pc_q       <= '0;
      req_inflight_q <= 1'b0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_pc_q       <= req_pc_d;
      req_inflight_q <= req_inflight_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
    end
  end

  // Entry storage. It has no reset because count_q gates visibility.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= ifq_io.in_pmem_word;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  push_never_full: assert property (@(posedge clock) disable iff (!reset)
      !(push && (count_q == CntW'(DEPTH))))
    else $error("ifetch_queue: push into full FIFO");

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue.
// Every cycle is compared against a queue-based reference model.
// Directed tables and sequences cover the start-up, stall, redirect, wrap and reset cases.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int Byp = 1;
`else
  localparam int Byp = 0;
`endif
  localparam int Depth = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ifetch_queue_if #(.PC_WIDTH(12), .PMEM_WORD_WIDTH(16), .DEPTH_LOG2(2)) ifq ();

  ifetch_queue #(
    .PC_WIDTH(12), .PMEM_WORD_WIDTH(16), .PC_INCREMENT(2),
    .DEPTH(4), .DEPTH_LOG2(2), .RESET_PC(0)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ifq_io (ifq)
  );

  function automatic logic [15:0] word_of(input logic [11:0] a);
    return {4'h0, a} ^ 16'hA5A5;
  endfunction

  // Program memory: registered read, data valid one edge after the address.
  always @(posedge clock) ifq.in_pmem_word <= word_of(ifq.out_pmem_addr);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO is a list of PCs, plus one outstanding request.
  logic [11:0] m_q [$];
  logic [11:0] m_fetch;
  logic [11:0] m_req;
  logic        m_infl;

  task automatic model_reset();
    m_q.delete();
    m_fetch = 12'h000;
    m_req   = 12'h000;
    m_infl  = 1'b0;
  endtask

  function automatic logic model_bypass(input logic s);
    return (Byp != 0) && (m_q.size() == 0) && m_infl && !s;
  endfunction

  task automatic model_edge(input logic s, input logic [11:0] br, input logic r);
    int  sz;
    logic consumed;
    if (s) begin
      m_q.delete();
      m_fetch = br;
      m_infl  = 1'b0;
    end else begin
      sz       = m_q.size();
      consumed = model_bypass(s) && r;
      if (sz != 0 && r) void'(m_q.pop_front());
      if (m_infl && !consumed) m_q.push_back(m_req);
      if (sz + int'(m_infl) < Depth) begin
        m_req   = m_fetch;
        m_fetch = m_fetch + 12'd2;
        m_infl  = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  logic        s_valid;
  logic [11:0] s_pc;
  logic [15:0] s_instr;
  logic [2:0]  s_level;
  logic [11:0] s_addr;

  // One cycle: apply inputs, sample mid-cycle and compare with the model, then advance.
  task automatic step(input logic s, input logic [11:0] br, input logic r);
    logic        e_valid;
    logic [11:0] e_pc;
    ifq.in_set_pc    = s;
    ifq.in_branch_pc = br;
    ifq.in_ready     = r;
    #3;
    s_valid = ifq.out_valid;
    s_pc    = ifq.out_pc;
    s_instr = ifq.out_instr;
    s_level = ifq.out_level;
    s_addr  = ifq.out_pmem_addr;
    e_valid = (m_q.size() != 0) || model_bypass(s);
    e_pc    = (m_q.size() != 0) ? m_q[0] : (model_bypass(s) ? m_req : 12'h000);
    chk("model valid", 32'(s_valid), 32'(e_valid));
    chk("model pc", 32'(s_pc), 32'(e_pc));
    chk("model instr", 32'(s_instr), e_valid ? 32'(word_of(e_pc)) : 32'h0);
    chk("model level", 32'(s_level), 32'(m_q.size()));
    chk("model addr", 32'(s_addr), 32'(m_fetch));
    @(posedge clock);
    model_edge(s, br, r);
    #1;
  endtask

  task automatic do_reset();
    ifq.in_set_pc    = 1'b0;
    ifq.in_branch_pc = 12'h000;
    ifq.in_ready     = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Accepts up to n valid head PCs while ready is held high, within a cycle budget.
  logic [11:0] got [$];
  task automatic collect(input int n, input int bound, output int first_k);
    got.delete();
    first_k = 0;
    for (int i = 1; i <= bound && got.size() < n; i++) begin
      step(1'b0, 12'h000, 1'b1);
      if (s_valid) begin
        if (got.size() == 0) first_k = i;
        got.push_back(s_pc);
      end
    end
    chk("collect count", 32'(got.size()), 32'(n));
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    logic        rdy;
    logic        exp_valid;
    logic [11:0] exp_pc;
    logic [2:0]  exp_level;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs [6];
  int   k;

  initial begin
    // Start-up stream after reset release, with fetch always ready.
`ifdef IFQ_BYPASS_EN
    vecs[0] = '{1'b1, 1'b0, 12'h000, 3'd0, 12'h000};
    vecs[1] = '{1'b1, 1'b1, 12'h000, 3'd0, 12'h002};
    vecs[2] = '{1'b1, 1'b1, 12'h002, 3'd0, 12'h004};
    vecs[3] = '{1'b1, 1'b1, 12'h004, 3'd0, 12'h006};
    vecs[4] = '{1'b1, 1'b1, 12'h006, 3'd0, 12'h008};
    vecs[5] = '{1'b1, 1'b1, 12'h008, 3'd0, 12'h00A};
`else
    vecs[0] = '{1'b1, 1'b0, 12'h000, 3'd0, 12'h000};
    vecs[1] = '{1'b1, 1'b0, 12'h000, 3'd0, 12'h002};
    vecs[2] = '{1'b1, 1'b1, 12'h000, 3'd1, 12'h004};
    vecs[3] = '{1'b1, 1'b1, 12'h002, 3'd1, 12'h006};
    vecs[4] = '{1'b1, 1'b1, 12'h004, 3'd1, 12'h008};
    vecs[5] = '{1'b1, 1'b1, 12'h006, 3'd1, 12'h00A};
`endif

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 12'h000, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d pc", i), 32'(s_pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d instr", i), 32'(s_instr),
          vecs[i].exp_valid ? 32'(word_of(vecs[i].exp_pc)) : 32'h0);
      chk($sformatf("vec%0d level", i), 32'(s_level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d addr", i), 32'(s_addr), 32'(vecs[i].exp_addr));
    end

    // Stall: the queue fills up and fetching stops at 0x008.
    do_reset();
    repeat (10) step(1'b0, 12'h000, 1'b0);
    chk("stall level", 32'(s_level), 32'd4);
    chk("stall addr", 32'(s_addr), 32'h008);
    collect(5, 12, k);
    chk("stall no bubble", 32'(k), 32'd1);
    for (int i = 0; i < 5; i++) chk($sformatf("stall pc%0d", i), got_at(i), 32'(2 * i));

    // Redirect while full: flush next cycle, target arrives two edges later.
    repeat (8) step(1'b0, 12'h000, 1'b0);
    chk("pre-redirect level", 32'(s_level), 32'd4);
    step(1'b1, 12'h100, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    chk("redirect flush level", 32'(s_level), 32'd0);
    chk("redirect flush valid", 32'(s_valid), 32'd0);
    collect(3, 8, k);
    chk("redirect latency", 32'(k), (Byp != 0) ? 32'd1 : 32'd2);
    for (int i = 0; i < 3; i++) chk($sformatf("redirect pc%0d", i), got_at(i), 32'h100 + 32'(2 * i));

    // PC wrap at the top of the address space.
    step(1'b1, 12'hFFC, 1'b1);
    collect(4, 10, k);
    chk("wrap pc0", got_at(0), 32'hFFC);
    chk("wrap pc1", got_at(1), 32'hFFE);
    chk("wrap pc2", got_at(2), 32'h000);
    chk("wrap pc3", got_at(3), 32'h002);

    // Asynchronous reset with three entries queued.
    do_reset();
    repeat (4) step(1'b0, 12'h000, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async rst valid", 32'(ifq.out_valid), 32'd0);
    chk("async rst level", 32'(ifq.out_level), 32'd0);
    chk("async rst addr", 32'(ifq.out_pmem_addr), 32'h000);
    @(posedge clock);
    #1;
    chk("held rst valid", 32'(ifq.out_valid), 32'd0);
    chk("held rst addr", 32'(ifq.out_pmem_addr), 32'h000);
    reset = 1'b1;
    collect(2, 6, k);
    chk("restart pc0", got_at(0), 32'h000);
    chk("restart pc1", got_at(1), 32'h002);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 20) == 0, 12'($urandom) & 12'hFFE, ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch queue between pmem_sim and the fetch stage.
- Drives the PMEM read address and captures returned words together with their PC in a small FIFO.
- Presents one instruction per cycle to fetch with a valid/ready handshake.
- Flushed by the EX-stage redirect (set_pc/branch_pc); decouples PMEM read latency from fetch-stage stalls.

Parameters:
- PC_WIDTH, 12, width of PC and PMEM address
- PMEM_WORD_WIDTH, 16, instruction word width
- PC_INCREMENT, 2, PC step per instruction
- DEPTH, 4, FIFO entries; power of 2, >=2
- DEPTH_LOG2, 2, log2(DEPTH)
- RESET_PC, 0, first fetch address after reset

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_set_pc  in  1  redirect request from EX
- in_branch_pc  in  PC_WIDTH  redirect target
- in_pmem_word  in  PMEM_WORD_WIDTH  PMEM read data; registered, valid one edge after address
- out_pmem_addr  out  PC_WIDTH  PMEM read address
- in_ready  in  1  fetch accepts head entry
- out_valid  out  1  head entry valid
- out_instr  out  PMEM_WORD_WIDTH  head instruction
- out_pc  out  PC_WIDTH  PC of head instruction
- out_level  out  DEPTH_LOG2+1  current entry count

Behaviour:
- State:
  - fetch_pc register, driven directly on out_pmem_addr.
  - req_inflight flag and req_pc register.
  - DEPTH x {instr, pc} storage.
  - rd_ptr, wr_ptr (DEPTH_LOG2 bits, wrap mod DEPTH).
  - count (DEPTH_LOG2+1 bits).
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, req_inflight=0, req_pc=0, ptrs=0, count=0. Outputs: out_valid=0, out_instr=0, out_pc=0, out_level=0, out_pmem_addr=RESET_PC. Storage contents don't care.
- Issue: issue = !in_set_pc && (count + req_inflight) < DEPTH.
  - On issue: req_inflight<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_INCREMENT (mod 2^PC_WIDTH, 0xFFE wraps to 0x000).
  - Otherwise (no issue, no redirect): req_inflight<=0, fetch_pc holds.
- Push: when req_inflight=1 and in_set_pc=0, write {in_pmem_word, req_pc} at wr_ptr and advance wr_ptr.
  - The issue rule guarantees push never occurs when full. A simulation assertion flags push with count==DEPTH.
- Pop: when out_valid && in_ready && !in_set_pc, advance rd_ptr.
  - Push and pop in the same cycle leave count unchanged.
- Head outputs: out_valid=(count!=0). out_instr/out_pc show the head entry, or 0 when empty. out_level=count.
- Redirect (in_set_pc=1) has priority over issue, push and pop. At the edge: fetch_pc<=in_branch_pc, req_inflight<=0, ptrs<=0, count<=0.
  - Any pop handshake in that cycle is void; the consumer also flushes.
- Latency (no bypass):
  - Reset release: first out_valid after the 2nd rising edge.
  - Redirect sampled at edge Eb: target instruction valid after Eb+2.
- Steady state with in_ready=1: one instruction per cycle, no bubbles.
- Reset mid-operation: all state returns to reset values immediately; no stale entry is output after release.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count==0 and req_inflight=1 and in_set_pc=0:
  - out_valid=1, out_instr=in_pmem_word, out_pc=req_pc combinationally.
  - If in_ready=1 the word is consumed and not pushed; otherwise it is pushed normally.
  - Effect: reset-to-first-valid and redirect latency each drop by one cycle.
- Undefined: all instructions pass through storage; latencies as above.

Test Plan:
- Release reset with RESET_PC=0, in_ready=1, PMEM holds word[a]=a^16'hA5A5 → out_valid rises after 2nd edge; out_pc sequence 0,2,4,6, each out_instr=word[pc], no gaps.
- Hold in_ready=0 for 10 cycles → out_level saturates at 4; out_pmem_addr stops at 0x008 (issued addresses 0..6 only). Then in_ready=1 → PCs 0,2,4,6,8 in order, none lost or duplicated.
- With queue full, assert in_set_pc=1, in_branch_pc=0x100 for one cycle while in_ready=1 → out_level=0 next cycle; first valid out_pc=0x100 two edges later; no pre-redirect PC appears afterwards.
- Redirect to 0xFFC with in_ready=1 → out_pc sequence 0xFFC, 0xFFE, 0x000, 0x002.
- Assert reset=0 mid-stream with 3 entries queued → out_valid=0, out_level=0, out_pmem_addr=RESET_PC while low; after release the stream restarts at RESET_PC.
- IFQ_BYPASS_EN defined: repeat the first and third scenarios → first valid and redirect target each arrive one edge earlier; PC/instr sequence identical.
